// File: rtl/arm_lp_pkg.sv
// ARM-LP shared definitions: decoded op types, sequencer
// stage encodings and trap cause codes.
package arm_lp_pkg;

    localparam logic [2:0] LD_TYPE  = 3'd0;
    localparam logic [2:0] CB_TYPE  = 3'd1;
    localparam logic [2:0] R_TYPE   = 3'd2;
    localparam logic [2:0] ST_TYPE  = 3'd3;
    localparam logic [2:0] I_TYPE   = 3'd4;
    localparam logic [2:0] B_TYPE   = 3'd5;
    localparam logic [2:0] M_TYPE   = 3'd6;
    localparam logic [2:0] BAD_TYPE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } stage_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_FETCH   = 2'd2,
        CAUSE_DATA    = 2'd3
    } cause_e;

    function automatic logic is_mem_type(input logic [2:0] t);
        return (t == LD_TYPE) || (t == ST_TYPE);
    endfunction

    function automatic logic has_writeback(input logic [2:0] t);
        return (t == LD_TYPE) || (t == R_TYPE) ||
               (t == I_TYPE)  || (t == M_TYPE);
    endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Saturating 8-bit wait counter for cache handshakes.
// expired flags count == MEM_TIMEOUT.
module wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] count;

    // clear wins over enable; count holds at all-ones
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and gates datapath enables.
module stage_sequencer
    import arm_lp_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 run,
    input  logic [2:0]           opType,
    input  logic                 imemReady,
    input  logic                 dmemReady,
    input  logic                 branchTaken,
    output logic                 fetchEnable,
    output logic                 irLoad,
    output logic                 aluEnable,
    output logic                 memReadStrobe,
    output logic                 memWriteStrobe,
    output logic                 regWriteEnable,
    output logic                 pcWrite,
    output logic                 pcSrc,
    output logic [2:0]           stage,
    output logic                 trap,
    output logic [1:0]           trapCause,
    output logic [CNT_WIDTH-1:0] retiredCount
);

    stage_e               state;
    stage_e               state_next;
    cause_e               cause;
    cause_e               cause_next;
    logic [2:0]           held_type;
    logic [CNT_WIDTH-1:0] retired;
    logic                 done;
    logic                 expired;
    logic                 timer_en;
    logic                 timer_clr;

    // timer runs only while a cache handshake is pending
    assign timer_en  = (state == S_FETCH  && !imemReady) ||
                       (state == S_MEMORY && !dmemReady);
    assign timer_clr = (state_next != state);

    wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clock  (clock),
        .resetN (resetN),
        .clear  (timer_clr),
        .enable (timer_en),
        .expired(expired)
    );

    // next stage, completion and trap cause selection
    always_comb begin
        state_next = state;
        cause_next = CAUSE_NONE;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imemReady) begin
                    state_next = S_DECODE;
                end else if (expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_FETCH;
                end
            end
            S_DECODE: begin
                if (opType == BAD_TYPE) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_mem_type(held_type)) begin
                    state_next = S_MEMORY;
                end else if (has_writeback(held_type)) begin
                    state_next = S_WRITEBACK;
                end else begin
                    done = 1'b1;
                end
            end
            S_MEMORY: begin
                if (dmemReady) begin
                    if (held_type == LD_TYPE) state_next = S_WRITEBACK;
                    else                      done       = 1'b1;
                end else if (expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_DATA;
                end
            end
            S_WRITEBACK: begin
                done = 1'b1;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (done) state_next = run ? S_FETCH : S_IDLE;
    end

    // stage register, held op type, frozen cause, retire count
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            held_type <= LD_TYPE;
            cause     <= CAUSE_NONE;
            retired   <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) held_type <= opType;
            if (state != S_TRAP && state_next == S_TRAP) begin
                cause <= cause_next;
            end
            if (done) retired <= retired + CNT_WIDTH'(1);
        end
    end

    // datapath enables decoded from the stage register
    always_comb begin
        fetchEnable    = (state == S_FETCH);
        irLoad         = (state == S_FETCH) && imemReady;
        aluEnable      = (state == S_EXECUTE);
        memReadStrobe  = (state == S_MEMORY) && (held_type == LD_TYPE);
        memWriteStrobe = (state == S_MEMORY) && (held_type == ST_TYPE);
        regWriteEnable = (state == S_WRITEBACK);
        pcWrite        = done;
        pcSrc          = (state == S_EXECUTE) &&
                         ((held_type == B_TYPE) ||
                          (held_type == CB_TYPE && branchTaken));
        trap           = (state == S_TRAP);
    end

    assign stage        = state;
    assign trapCause    = cause;
    assign retiredCount = retired;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: table of instructions checked via a
// scoreboard queue, plus hand sequences for traps, reset and wrap.
`timescale 1ns/1ps
module tb_stage_sequencer;

    localparam int TMO = 15;
    localparam int CW  = 4;

    localparam logic [2:0] OP_LD = 3'd0;
    localparam logic [2:0] OP_CB = 3'd1;
    localparam logic [2:0] OP_R  = 3'd2;
    localparam logic [2:0] OP_ST = 3'd3;
    localparam logic [2:0] OP_I  = 3'd4;
    localparam logic [2:0] OP_B  = 3'd5;
    localparam logic [2:0] OP_M  = 3'd6;
    localparam logic [2:0] OP_X  = 3'd7;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          run = 1'b0;
    logic [2:0]    opType = 3'd0;
    logic          imemReady = 1'b0;
    logic          dmemReady = 1'b0;
    logic          branchTaken = 1'b0;
    logic          fetchEnable;
    logic          irLoad;
    logic          aluEnable;
    logic          memReadStrobe;
    logic          memWriteStrobe;
    logic          regWriteEnable;
    logic          pcWrite;
    logic          pcSrc;
    logic [2:0]    stage;
    logic          trap;
    logic [1:0]    trapCause;
    logic [CW-1:0] retiredCount;

    stage_sequencer #(
        .MEM_TIMEOUT(TMO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .run           (run),
        .opType        (opType),
        .imemReady     (imemReady),
        .dmemReady     (dmemReady),
        .branchTaken   (branchTaken),
        .fetchEnable   (fetchEnable),
        .irLoad        (irLoad),
        .aluEnable     (aluEnable),
        .memReadStrobe (memReadStrobe),
        .memWriteStrobe(memWriteStrobe),
        .regWriteEnable(regWriteEnable),
        .pcWrite       (pcWrite),
        .pcSrc         (pcSrc),
        .stage         (stage),
        .trap          (trap),
        .trapCause     (trapCause),
        .retiredCount  (retiredCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        logic       br;
        int         fw;
        int         dw;
    } vec_t;

    typedef struct {
        int          cycles;
        int          fetch;
        int          irl;
        int          alu;
        int          rd;
        int          wr;
        int          rw;
        int          pcs;
        logic [63:0] sig;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   model_retired = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic mem;
        logic wb;
        mem = (v.op == OP_LD) || (v.op == OP_ST);
        wb  = (v.op == OP_LD) || (v.op == OP_R) ||
              (v.op == OP_I)  || (v.op == OP_M);
        e.fetch  = 1 + v.fw;
        e.irl    = 1;
        e.alu    = 1;
        e.rd     = (v.op == OP_LD) ? 1 + v.dw : 0;
        e.wr     = (v.op == OP_ST) ? 1 + v.dw : 0;
        e.rw     = wb ? 1 : 0;
        e.cycles = e.fetch + 2 + (mem ? 1 + v.dw : 0) + (wb ? 1 : 0);
        e.pcs    = (v.op == OP_B || (v.op == OP_CB && v.br)) ? 1 : 0;
        e.sig    = '0;
        for (int k = 0; k < e.fetch; k++) e.sig = (e.sig << 3) | 64'd1;
        e.sig = (e.sig << 3) | 64'd2;
        e.sig = (e.sig << 3) | 64'd3;
        if (mem) begin
            for (int k = 0; k <= v.dw; k++) e.sig = (e.sig << 3) | 64'd4;
        end
        if (wb) e.sig = (e.sig << 3) | 64'd5;
        return e;
    endfunction

    // Runs one instruction; readies are driven just after each rising
    // edge from the current stage, outputs sampled on the falling edge.
    task automatic run_instr(input vec_t v, input int idx, input bit drop);
        int   fcnt = 0;
        int   dcnt = 0;
        int   guard = 0;
        bit   done = 0;
        exp_t got;
        exp_t e;
        got = '{default: 0};
        opType = v.op;
        branchTaken = v.br;
        sb.push_back(model(v));
        while (!done && guard < 200) begin
            @(posedge clock);
            #1;
            guard++;
            if (stage == 3'd1) begin
                imemReady = (fcnt >= v.fw);
                fcnt++;
            end else begin
                imemReady = 1'b1;
            end
            if (stage == 3'd4) begin
                dmemReady = (dcnt >= v.dw);
                dcnt++;
            end else begin
                dmemReady = 1'b1;
            end
            if (drop && stage == 3'd2) run = 1'b0;
            @(negedge clock);
            if (stage != 3'd0) begin
                got.cycles++;
                got.sig = (got.sig << 3) | 64'(stage);
            end
            if (fetchEnable)    got.fetch++;
            if (irLoad)         got.irl++;
            if (aluEnable)      got.alu++;
            if (memReadStrobe)  got.rd++;
            if (memWriteStrobe) got.wr++;
            if (regWriteEnable) got.rw++;
            if (pcWrite) begin
                got.pcs = int'(pcSrc);
                done = 1;
                chk($sformatf("i%0d_retired", idx), 64'(retiredCount),
                    64'(model_retired % 16));
            end
        end
        chk($sformatf("i%0d_completed", idx), 64'(done), 64'd1);
        e = sb.pop_front();
        chk($sformatf("i%0d_cycles", idx), 64'(got.cycles), 64'(e.cycles));
        chk($sformatf("i%0d_stages", idx), got.sig, e.sig);
        chk($sformatf("i%0d_fetch", idx), 64'(got.fetch), 64'(e.fetch));
        chk($sformatf("i%0d_irload", idx), 64'(got.irl), 64'(e.irl));
        chk($sformatf("i%0d_alu", idx), 64'(got.alu), 64'(e.alu));
        chk($sformatf("i%0d_memrd", idx), 64'(got.rd), 64'(e.rd));
        chk($sformatf("i%0d_memwr", idx), 64'(got.wr), 64'(e.wr));
        chk($sformatf("i%0d_regwr", idx), 64'(got.rw), 64'(e.rw));
        chk($sformatf("i%0d_pcsrc", idx), 64'(got.pcs), 64'(e.pcs));
        model_retired++;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 resetN = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
    endtask

    task automatic wait_stage(input logic [2:0] s, input int lim,
                              input string name);
        int n = 0;
        while (stage !== s && n < lim) begin
            @(negedge clock);
            n++;
        end
        chk(name, 64'(stage), 64'(s));
    endtask

    task automatic poke_trap(input logic [1:0] cause, input string name);
        logic any;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            run = 1'($urandom);
            imemReady = 1'($urandom);
            dmemReady = 1'($urandom);
            branchTaken = 1'($urandom);
            opType = 3'($urandom);
            @(negedge clock);
            any = fetchEnable | irLoad | aluEnable | memReadStrobe |
                  memWriteStrobe | regWriteEnable | pcWrite | pcSrc;
            chk($sformatf("%s_stay%0d", name, i), 64'(stage), 64'd6);
            chk($sformatf("%s_cause%0d", name, i), 64'(trapCause),
                64'(cause));
            chk($sformatf("%s_quiet%0d", name, i), 64'(any), 64'd0);
        end
    endtask

    initial begin
        vec_t tbl[12];
        vec_t vb;
        int   n;
        logic any;

        tbl = '{
            '{OP_R,  1'b0, 0,  0},
            '{OP_LD, 1'b0, 0,  3},
            '{OP_CB, 1'b1, 0,  0},
            '{OP_CB, 1'b0, 0,  0},
            '{OP_ST, 1'b0, 0,  0},
            '{OP_I,  1'b0, 0,  0},
            '{OP_M,  1'b0, 0,  0},
            '{OP_B,  1'b0, 0,  0},
            '{OP_LD, 1'b0, 2,  1},
            '{OP_ST, 1'b0, 1,  2},
            '{OP_CB, 1'b1, 15, 0},
            '{OP_ST, 1'b0, 0,  15}
        };

        repeat (2) @(negedge clock);
        any = fetchEnable | irLoad | aluEnable | memReadStrobe |
              memWriteStrobe | regWriteEnable | pcWrite | pcSrc;
        chk("rst_stage", 64'(stage), 64'd0);
        chk("rst_strobes", 64'(any), 64'd0);
        chk("rst_trap", 64'(trap), 64'd0);
        chk("rst_cause", 64'(trapCause), 64'd0);
        chk("rst_retired", 64'(retiredCount), 64'd0);

        @(posedge clock);
        #1 resetN = 1'b1;
        run = 1'b1;

        for (int i = 0; i < 12; i++) run_instr(tbl[i], i, 1'b0);
        vb = '{OP_B, 1'b0, 0, 0};
        for (int i = 0; i < 4; i++) run_instr(vb, 12 + i, 1'b0);

        // 17th instruction: count shown at completion has wrapped to 0
        vb = '{OP_ST, 1'b0, 0, 0};
        run_instr(vb, 16, 1'b1);
        @(negedge clock);
        chk("drop_idle", 64'(stage), 64'd0);
        chk("drop_retired", 64'(retiredCount), 64'd1);
        @(negedge clock);
        chk("drop_idle2", 64'(stage), 64'd0);

        // illegal op type
        @(posedge clock);
        #1;
        opType = OP_X;
        imemReady = 1'b1;
        dmemReady = 1'b1;
        run = 1'b1;
        wait_stage(3'd6, 10, "ill_stage");
        chk("ill_cause", 64'(trapCause), 64'd1);
        chk("ill_trap", 64'(trap), 64'd1);
        chk("ill_retired", 64'(retiredCount), 64'd1);
        poke_trap(2'd1, "ill");
        do_reset();
        @(negedge clock);
        chk("ill_rst_stage", 64'(stage), 64'd0);
        chk("ill_rst_cause", 64'(trapCause), 64'd0);
        chk("ill_rst_retired", 64'(retiredCount), 64'd0);

        // fetch timeout: 16 FETCH cycles with ready low, then TRAP
        @(posedge clock);
        #1;
        run = 1'b1;
        opType = OP_R;
        imemReady = 1'b0;
        dmemReady = 1'b1;
        n = 0;
        for (int g = 0; g < 60 && stage != 3'd6; g++) begin
            @(negedge clock);
            if (stage == 3'd1) n++;
        end
        chk("ftmo_cycles", 64'(n), 64'(TMO + 1));
        chk("ftmo_stage", 64'(stage), 64'd6);
        chk("ftmo_cause", 64'(trapCause), 64'd2);
        chk("ftmo_trap", 64'(trap), 64'd1);
        poke_trap(2'd2, "ftmo");
        do_reset();

        // data timeout on a store
        @(posedge clock);
        #1;
        run = 1'b1;
        opType = OP_ST;
        imemReady = 1'b1;
        dmemReady = 1'b0;
        n = 0;
        for (int g = 0; g < 60 && stage != 3'd6; g++) begin
            @(negedge clock);
            if (memWriteStrobe) n++;
        end
        chk("dtmo_cycles", 64'(n), 64'(TMO + 1));
        chk("dtmo_stage", 64'(stage), 64'd6);
        chk("dtmo_cause", 64'(trapCause), 64'd3);
        chk("dtmo_retired", 64'(retiredCount), 64'd0);
        do_reset();

        // asynchronous reset during a store memory wait
        @(posedge clock);
        #1;
        run = 1'b1;
        opType = OP_ST;
        imemReady = 1'b1;
        dmemReady = 1'b0;
        wait_stage(3'd4, 10, "arst_mem");
        @(negedge clock);
        chk("arst_wr_before", 64'(memWriteStrobe), 64'd1);
        #2 resetN = 1'b0;
        #1;
        chk("arst_wr_after", 64'(memWriteStrobe), 64'd0);
        chk("arst_stage", 64'(stage), 64'd0);
        any = fetchEnable | aluEnable | memReadStrobe | regWriteEnable;
        chk("arst_quiet", 64'(any), 64'd0);
        @(posedge clock);
        #1 resetN = 1'b1;
        run = 1'b0;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle stage sequencer for the ARM-LP core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, choosing the stage path from the decoder's `opType`. It waits on instruction-cache and data-cache ready handshakes and gates the PC, instruction register, ALU, data-cache and register-file enables, so one datapath is shared across cycles. It sits between the decoder/controller and the PC, caches and register file.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles on a cache handshake before trapping (1..255).
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.

- `clock` input 1: single clock; all state changes on the rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `run` input 1: enables starting the next instruction.
- `opType` input 3: decoded type; LD=0, CB=1, R=2, ST=3, I=4, B=5, M=6. Value 7 is illegal.
- `imemReady` input 1: instruction cache has valid data.
- `dmemReady` input 1: data cache has completed the access.
- `branchTaken` input 1: ALU zero result qualified for CB, sampled in EXECUTE.
- `fetchEnable` output 1: instruction-cache read request.
- `irLoad` output 1: latch the instruction register.
- `aluEnable` output 1: ALU operand/result registers update.
- `memReadStrobe` output 1: data-cache read request.
- `memWriteStrobe` output 1: data-cache write request.
- `regWriteEnable` output 1: register-file write.
- `pcWrite` output 1: PC update pulse.
- `pcSrc` output 1: 0 selects PC+4; 1 selects the branch target.
- `stage` output 3: current state encoding.
- `trap` output 1: sticky error flag.
- `trapCause` output 2: 0 none, 1 illegal opType, 2 fetch timeout, 3 data timeout.
- `retiredCount` output CNT_WIDTH: number of completed instructions.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6.
- IDLE: go to FETCH when `run`=1.
- FETCH: `fetchEnable`=1. Stay while `imemReady`=0. When `imemReady`=1, assert `irLoad` that cycle and go to DECODE.
- DECODE: one cycle. `opType` is sampled here and held in an internal register for the rest of the instruction. opType 7 goes to TRAP with cause 1.
- EXECUTE: `aluEnable`=1 for one cycle. Next state by held type:
  - LD and ST go to MEMORY.
  - R, I and M go to WRITEBACK.
  - CB and B complete here.
- MEMORY: `memReadStrobe`=1 (LD) or `memWriteStrobe`=1 (ST), held until `dmemReady`=1. Then LD goes to WRITEBACK and ST completes.
- WRITEBACK: `regWriteEnable`=1 for one cycle, then the instruction completes.
- Completion cycle:
  - `pcWrite`=1 for one cycle.
  - `pcSrc`=1 only for B, or for CB with `branchTaken`=1.
  - `retiredCount` increments and wraps at 2^CNT_WIDTH.
  - Next state is FETCH if `run`=1, else IDLE.
- Wait timer: counts cycles spent in FETCH or MEMORY with ready low, and clears on every state change. When it reaches MEM_TIMEOUT with ready still low, the next state is TRAP with cause 2 or 3.
- TRAP:
  - All strobes are 0 and `trap`=1.
  - `trapCause` is frozen.
  - The only exit is `resetN`.
- `run` deasserted mid-instruction does not abort; it only takes effect at completion.

## Timing
- Reset values: state IDLE, all strobes 0, `pcSrc`=0, `trap`=0, `trapCause`=0, `retiredCount`=0, timer 0.
- Asserting `resetN` low mid-instruction forces IDLE immediately (asynchronous). No strobe may remain high after reset.
- Strobes are Moore outputs decoded from the state register, plus held type and `branchTaken` for `pcSrc`. There are no combinational paths from the ready inputs to the strobes.
- Latency with zero-wait caches (ready already high on state entry), FETCH to completion inclusive:
  - LD: 5 cycles.
  - ST, R, I, M: 4 cycles.
  - CB, B: 3 cycles.
- Each wait cycle adds exactly one cycle.
- `dmemReady`/`imemReady` high outside MEMORY/FETCH is ignored.
- Ready arriving on the same cycle the timer reaches MEM_TIMEOUT counts as success; no trap.

## Structure
- Shared package `arm_lp_pkg`:
  - opType constants (LD_TYPE … M_TYPE, shared with the decoder).
  - state encodings.
  - trapCause codes.
- One sub-module, `wait_timer`: 8-bit saturating counter with clear, enable and `expired` output (count == MEM_TIMEOUT).
- Everything else (next-state logic, output decode, held type, retired counter) lives in `stage_sequencer`.

## Test plan
- Reset, `run`=1, both ready tied high, opType R → `stage` 1,2,3,5 on consecutive cycles; `regWriteEnable` only in cycle 4; `pcWrite` once with `pcSrc`=0; `retiredCount`=1.
- LD with `dmemReady` low for 3 MEMORY cycles → `memReadStrobe` high 4 cycles; `regWriteEnable` in WRITEBACK; total 8 cycles.
- CB with `branchTaken`=1, then CB with `branchTaken`=0 → 3 cycles each, `pcSrc` 1 then 0; no `memReadStrobe`/`memWriteStrobe`/`regWriteEnable` ever asserted.
- `imemReady` held low with MEM_TIMEOUT=15 → TRAP after 15 FETCH wait cycles, `trapCause`=2; state stays TRAP under further stimulus until `resetN` pulse.
- opType=7 at DECODE → TRAP, `trapCause`=1, `retiredCount` unchanged. Separately, `resetN` low during a ST MEMORY wait → `memWriteStrobe` drops immediately and `stage`=0.
- `run` dropped mid-ST → ST completes, then IDLE. With CNT_WIDTH=4, 16 retirements wrap `retiredCount` to 0.
